// File: rtl/switch_ctrl_sequencer.sv
// Command-FIFO driven sequencer for the inter-switch ctrl/weight_switch inputs.
// Optional statistics counters are enabled with `define SWITCH_SEQ_STATS_EN.
module switch_ctrl_sequencer #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned CNT_W     = 16,
    parameter logic [18:0] IDLE_CTRL = 19'h10080
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W+19:0] s_cmd_tdata,
    input  logic             s_cmd_tvalid,
    output logic             s_cmd_tready,
    output logic [18:0]      ctrl,
    output logic             weight_switch,
    input  logic             count_switch_tvalid,
    output logic             busy,
    output logic             cmd_done
`ifdef SWITCH_SEQ_STATS_EN
    ,
    output logic [31:0]      stat_cmd_cnt,
    output logic [31:0]      stat_stall_cnt
`endif
);

    localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state;
    logic [CNT_W+19:0] mem [CMD_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              last_beat;
    logic [CNT_W+19:0] head;
    logic [CNT_W-1:0]  cur_len;
    logic [CNT_W-1:0]  beat_cnt;

    assign full         = (count == (AW+1)'(CMD_DEPTH));
    assign empty        = (count == '0);
    assign s_cmd_tready = ~full;
    assign busy         = (state == S_RUN) | ~empty;
    assign head         = mem[rd_ptr];

    // Push is gated by ~full, so a full FIFO only ever sees the pop.
    always_comb begin
        push      = s_cmd_tvalid & ~full;
        last_beat = (state == S_RUN) & count_switch_tvalid & (beat_cnt == cur_len);
        pop       = ~empty & ((state == S_IDLE) | last_beat);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_cmd_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ctrl/weight_switch are loaded from the FIFO head so they stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cur_len       <= '0;
            beat_cnt      <= '0;
            ctrl          <= IDLE_CTRL;
            weight_switch <= 1'b0;
            cmd_done      <= 1'b0;
        end else begin
            cmd_done <= last_beat;
            if (pop) begin
                state         <= S_RUN;
                cur_len       <= head[CNT_W+19:20];
                beat_cnt      <= '0;
                ctrl          <= head[18:0];
                weight_switch <= head[19];
            end else if (last_beat) begin
                state         <= S_IDLE;
                ctrl          <= IDLE_CTRL;
                weight_switch <= 1'b0;
            end else if ((state == S_RUN) && count_switch_tvalid) begin
                beat_cnt      <= beat_cnt + CNT_W'(1);
                weight_switch <= 1'b0;
            end
        end
    end

`ifdef SWITCH_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cmd_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (cmd_done && (stat_cmd_cnt != '1)) begin
                stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
            end
            if ((state == S_RUN) && !count_switch_tvalid && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_ctrl_sequencer.sv
// Directed self-checking bench for switch_ctrl_sequencer.
module tb_switch_ctrl_sequencer;

    localparam logic [18:0] IDLE = 19'h10080;

    logic        clk;
    logic        rst_n;
    logic [35:0] s_cmd_tdata;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic [18:0] ctrl;
    logic        weight_switch;
    logic        hs;
    logic        busy;
    logic        cmd_done;
`ifdef SWITCH_SEQ_STATS_EN
    logic [31:0] stat_cmd_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    switch_ctrl_sequencer #(
        .CMD_DEPTH(4),
        .CNT_W    (16),
        .IDLE_CTRL(19'h10080)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_cmd_tdata        (s_cmd_tdata),
        .s_cmd_tvalid       (s_cmd_tvalid),
        .s_cmd_tready       (s_cmd_tready),
        .ctrl               (ctrl),
        .weight_switch      (weight_switch),
        .count_switch_tvalid(hs),
        .busy               (busy),
        .cmd_done           (cmd_done)
`ifdef SWITCH_SEQ_STATS_EN
        ,
        .stat_cmd_cnt       (stat_cmd_cnt),
        .stat_stall_cnt     (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [18:0] c, input logic f, input logic [15:0] lm1);
        return {lm1, f, c};
    endfunction

    initial begin
        int done_seen;
        rst_n        = 1'b0;
        s_cmd_tvalid = 1'b0;
        s_cmd_tdata  = '0;
        hs           = 1'b0;
        repeat (3) step();
        chk("rst_ctrl", 36'(ctrl), 36'(IDLE));
        chk("rst_ws", 36'(weight_switch), 36'(0));
        chk("rst_busy", 36'(busy), 36'(0));
        chk("rst_tready", 36'(s_cmd_tready), 36'(1));
        chk("rst_done", 36'(cmd_done), 36'(0));
`ifdef SWITCH_SEQ_STATS_EN
        chk("rst_stat_cmd", 36'(stat_cmd_cnt), 36'(0));
        chk("rst_stat_stall", 36'(stat_stall_cnt), 36'(0));
`endif
        rst_n = 1'b1;
        step();

        // Single command, len 4, flag set
        s_cmd_tdata  = mk(19'h00011, 1'b1, 16'd3);
        s_cmd_tvalid = 1'b1;
        step();
        s_cmd_tvalid = 1'b0;
        chk("single_push_ctrl", 36'(ctrl), 36'(IDLE));
        chk("single_push_busy", 36'(busy), 36'(1));
        step();
        chk("single_pop_ctrl", 36'(ctrl), 36'(19'h00011));
        chk("single_pop_ws", 36'(weight_switch), 36'(1));
        hs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_hold_ctrl", 36'(ctrl), 36'(19'h00011));
            chk("single_hold_ws", 36'(weight_switch), 36'(0));
            chk("single_hold_done", 36'(cmd_done), 36'(0));
        end
        step();
        chk("single_end_ctrl", 36'(ctrl), 36'(IDLE));
        chk("single_end_done", 36'(cmd_done), 36'(1));
        chk("single_end_busy", 36'(busy), 36'(0));
        step();
        chk("idle_hs_done", 36'(cmd_done), 36'(0));
        chk("idle_hs_ctrl", 36'(ctrl), 36'(IDLE));
        chk("idle_hs_busy", 36'(busy), 36'(0));
        hs = 1'b0;

        // Back-to-back: len 2 then len 1
        s_cmd_tdata  = mk(19'h00011, 1'b0, 16'd1);
        s_cmd_tvalid = 1'b1;
        step();
        s_cmd_tdata  = mk(19'h000B2, 1'b1, 16'd0);
        step();
        s_cmd_tvalid = 1'b0;
        chk("b2b_a_ctrl", 36'(ctrl), 36'(19'h00011));
        chk("b2b_a_ws", 36'(weight_switch), 36'(0));
        hs = 1'b1;
        step();
        chk("b2b_a_hold", 36'(ctrl), 36'(19'h00011));
        chk("b2b_a_nodone", 36'(cmd_done), 36'(0));
        step();
        chk("b2b_b_ctrl", 36'(ctrl), 36'(19'h000B2));
        chk("b2b_b_ws", 36'(weight_switch), 36'(1));
        chk("b2b_done1", 36'(cmd_done), 36'(1));
        chk("b2b_b_busy", 36'(busy), 36'(1));
        step();
        chk("b2b_end_ctrl", 36'(ctrl), 36'(IDLE));
        chk("b2b_done2", 36'(cmd_done), 36'(1));
        chk("b2b_end_busy", 36'(busy), 36'(0));
        hs = 1'b0;
        step();
        chk("b2b_done_clr", 36'(cmd_done), 36'(0));

        // Stall: len 4, handshake every other cycle
        s_cmd_tdata  = mk(19'h00055, 1'b0, 16'd3);
        s_cmd_tvalid = 1'b1;
        step();
        s_cmd_tvalid = 1'b0;
        step();
        chk("stall_start", 36'(ctrl), 36'(19'h00055));
        for (int i = 0; i < 8; i++) begin
            hs = (i % 2 == 1);
            step();
            if (i < 7) begin
                chk("stall_hold", 36'(ctrl), 36'(19'h00055));
            end else begin
                chk("stall_end_ctrl", 36'(ctrl), 36'(IDLE));
                chk("stall_end_done", 36'(cmd_done), 36'(1));
            end
        end
        hs = 1'b0;
        step();
`ifdef SWITCH_SEQ_STATS_EN
        chk("stat_stall", 36'(stat_stall_cnt), 36'(4));
        chk("stat_cmd", 36'(stat_cmd_cnt), 36'(4));
`endif

        // FIFO full: first command stalls, four more fill the FIFO, sixth waits
        for (int k = 0; k < 5; k++) begin
            s_cmd_tdata  = mk(19'(19'h101 + k), 1'b0, 16'd0);
            s_cmd_tvalid = 1'b1;
            step();
        end
        chk("full_tready", 36'(s_cmd_tready), 36'(0));
        chk("full_ctrl", 36'(ctrl), 36'(19'h00101));
        s_cmd_tdata = mk(19'h00106, 1'b0, 16'd0);
        step();
        step();
        chk("full_blocked", 36'(s_cmd_tready), 36'(0));
        chk("full_stalled", 36'(ctrl), 36'(19'h00101));
        hs = 1'b1;
        step();
        chk("full_pop_ctrl", 36'(ctrl), 36'(19'h00102));
        chk("full_pop_tready", 36'(s_cmd_tready), 36'(1));
        hs = 1'b0;
        step();
        chk("full_pending_in", 36'(s_cmd_tready), 36'(0));
        chk("full_pending_ctrl", 36'(ctrl), 36'(19'h00102));
        s_cmd_tvalid = 1'b0;
        hs = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("full_drain", 36'(ctrl), 36'(19'(19'h103 + k)));
        end
        step();
        chk("full_drain_idle", 36'(ctrl), 36'(IDLE));
        chk("full_drain_busy", 36'(busy), 36'(0));
        hs = 1'b0;

        // Reset mid-run with two commands queued
        s_cmd_tdata  = mk(19'h000AA, 1'b0, 16'd7);
        s_cmd_tvalid = 1'b1;
        step();
        s_cmd_tdata = mk(19'h000BB, 1'b0, 16'd0);
        step();
        s_cmd_tdata = mk(19'h000CC, 1'b0, 16'd0);
        step();
        s_cmd_tvalid = 1'b0;
        chk("mid_run_ctrl", 36'(ctrl), 36'(19'h000AA));
        hs = 1'b1;
        step();
        chk("mid_beat1", 36'(ctrl), 36'(19'h000AA));
        rst_n = 1'b0;
        step();
        chk("mid_rst_ctrl", 36'(ctrl), 36'(IDLE));
        chk("mid_rst_busy", 36'(busy), 36'(0));
        chk("mid_rst_tready", 36'(s_cmd_tready), 36'(1));
        chk("mid_rst_done", 36'(cmd_done), 36'(0));
`ifdef SWITCH_SEQ_STATS_EN
        chk("mid_rst_stat_cmd", 36'(stat_cmd_cnt), 36'(0));
        chk("mid_rst_stat_stall", 36'(stat_stall_cnt), 36'(0));
`endif
        rst_n = 1'b1;
        hs = 1'b0;
        step();
        step();
        chk("mid_flushed_busy", 36'(busy), 36'(0));
        chk("mid_flushed_ctrl", 36'(ctrl), 36'(IDLE));

        // Maximum length: 2^16 handshakes without early wrap
        s_cmd_tdata  = mk(19'h0007E, 1'b1, 16'hFFFF);
        s_cmd_tvalid = 1'b1;
        step();
        s_cmd_tvalid = 1'b0;
        step();
        chk("max_start_ctrl", 36'(ctrl), 36'(19'h0007E));
        chk("max_start_ws", 36'(weight_switch), 36'(1));
        hs = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 65535; i++) begin
            step();
            if (cmd_done) done_seen++;
        end
        chk("max_hold_ctrl", 36'(ctrl), 36'(19'h0007E));
        chk("max_no_early_done", 36'(done_seen), 36'(0));
        step();
        chk("max_end_ctrl", 36'(ctrl), 36'(IDLE));
        chk("max_end_done", 36'(cmd_done), 36'(1));
        hs = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_ctrl_sequencer.md
# switch_ctrl_sequencer

Command-driven controller that feeds the `ctrl` and `weight_switch` inputs of the inter-switch and tracks its accepted beats through `count_switch_tvalid`. It buffers routing commands in a small FIFO. Each command carries a 19-bit switch control word, a beat length and a weight-switch flag. The sequencer holds each control word for exactly the commanded number of accepted beats, then advances to the next command with no bubble.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO depth; power of two, ≥2
- `CNT_W`, 16: width of the beat-length field
- `IDLE_CTRL`, 19'h10080: control word driven when no command is active (no input selected)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `s_cmd_tdata`  in  20+CNT_W  command: [18:0] ctrl word, [19] weight flag, [19+CNT_W:20] beats-minus-one
- `s_cmd_tvalid`  in  1  command valid
- `s_cmd_tready`  out  1  FIFO not full
- `ctrl`  out  19  control word to the switch
- `weight_switch`  out  1  weight-switch marker to the switch
- `count_switch_tvalid`  in  1  switch input-side handshake strobe (one per accepted beat)
- `busy`  out  1  command active or FIFO non-empty
- `cmd_done`  out  1  one-cycle pulse per completed command
- `stat_cmd_cnt`  out  32  completed-command counter (only with `SWITCH_SEQ_STATS_EN`)
- `stat_stall_cnt`  out  32  RUN cycles without a handshake (only with `SWITCH_SEQ_STATS_EN`)

## Operation
- Command FIFO:
  - Push on `s_cmd_tvalid & s_cmd_tready`; `s_cmd_tready = ~full`, registered occupancy.
  - No pass-through when full: a pop and a push in the same cycle are both allowed unless the FIFO is full, in which case only the pop occurs.
  - Pointers wrap modulo `CMD_DEPTH`.
- FSM states:
  - IDLE: `ctrl = IDLE_CTRL`, `weight_switch = 0`. If the FIFO is non-empty, pop, load `cur_ctrl`, `cur_flag` and `cur_len`, clear `beat_cnt`, and go to RUN.
  - RUN: `ctrl = cur_ctrl`; `weight_switch = cur_flag & (beat_cnt == 0)`. Each `count_switch_tvalid` increments `beat_cnt`.
- Last beat in RUN (`count_switch_tvalid` while `beat_cnt == cur_len`):
  - Pulse `cmd_done` in the next cycle.
  - If the FIFO is non-empty, pop and load the next command in the same edge, staying in RUN (zero-bubble).
  - Otherwise return to IDLE.
- `count_switch_tvalid` in IDLE is ignored.
- `beat_cnt` is CNT_W bits wide. `cur_len = 2^CNT_W−1` is legal and does not wrap before the terminal compare.
- `busy = (state == RUN) | ~empty`.

## Timing
- Reset values:
  - `ctrl = IDLE_CTRL`, `weight_switch = 0`, `cmd_done = 0`, `busy = 0`.
  - `s_cmd_tready = 1`; FIFO empty.
  - Statistics counters 0.
- Reset asserted mid-command aborts it: the FIFO is flushed and the outputs return to their reset values on the next edge.
- Latency, push to active control word: the edge at which a command is accepted into an empty FIFO with the FSM in IDLE is edge T. The pop happens at edge T+1, and `ctrl` shows the new word from edge T+1 onward.
- All outputs are registered except `s_cmd_tready` and `busy`, which are derived from registered state only.
- A command of length N holds `ctrl` for exactly N handshakes. The next command's word appears at the edge on which the N-th handshake is sampled.
- `cmd_done` is high for exactly one cycle, the cycle after the terminal handshake edge.

## Configuration
- `SWITCH_SEQ_STATS_EN` defined:
  - `stat_cmd_cnt` increments on every `cmd_done`.
  - `stat_stall_cnt` increments every RUN cycle with `count_switch_tvalid = 0`.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF; both clear on reset.
- `SWITCH_SEQ_STATS_EN` undefined: both ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n = 0` for 3 cycles → `ctrl = 19'h10080`, `weight_switch = 0`, `busy = 0`, `s_cmd_tready = 1`.
- **Single command:** ctrl=19'h00011, flag=1, beats−1=3, `count_switch_tvalid` every cycle →
  - `ctrl = 19'h00011` for 4 handshakes;
  - `weight_switch` high only before the first handshake;
  - `cmd_done` pulses once, then `ctrl = 19'h10080`.
- **Back-to-back:** queue two commands (19'h00011 len 2, 19'h000B2 len 1) with continuous handshakes → `ctrl` switches to 19'h000B2 at the edge of the 2nd handshake with no IDLE cycle; `cmd_done` pulses twice.
- **Stall:** RUN with `count_switch_tvalid` gapped every other cycle, len 4 →
  - `ctrl` is held for 8 cycles;
  - with `SWITCH_SEQ_STATS_EN`, `stat_stall_cnt = 4`.
- **FIFO full:** push 5 commands with `CMD_DEPTH = 4` while the first is stalled with no handshakes → `s_cmd_tready` deasserts after the FIFO fills; the pending push completes only after the first pop.
- **Reset mid-run:** assert `rst_n = 0` at the 2nd beat of a len-8 command with 2 commands queued → the next cycle shows `ctrl = 19'h10080` and `busy = 0`; the queued commands are discarded.
